// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared types, widths and the ALU datapath helper used by the
// execute stage, its multiplier sub-module, its port interface and the bench.
package ex_stage_pkg;

  localparam int RS_SZ           = 16;
  localparam int RS_IDX_W        = $clog2(RS_SZ);
  localparam int TAG_W           = 6;
  localparam int MULT_STAGES_DEF = 4;

  typedef logic [TAG_W-1:0]    TAG;
  typedef logic [RS_IDX_W-1:0] RS_IDX;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU
  } ALU_FUNC;

  // Returned to the reservation station so it can free the issuing slot.
  typedef struct packed {
    logic  remove_en;
    RS_IDX remove_idx;
  } EX_RS_PACKET;

  // A finished (or in-flight) result headed for the CDB.
  typedef struct packed {
    logic        valid;
    TAG          tag;
    RS_IDX       rs_idx;
    logic [31:0] value;
  } EX_RESULT;

  // Result payload without its valid bit, for storage that is never reset.
  typedef struct packed {
    TAG          tag;
    RS_IDX       rs_idx;
    logic [31:0] value;
  } EX_PAYLOAD;

  function automatic logic is_mult_func(ALU_FUNC f);
    return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  // Single-cycle integer ALU; shift amount is the low five bits of b.
  function automatic logic [31:0] alu_compute(ALU_FUNC f, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (f)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: issue-side handshake plus CDB / RS-return bus of ex_stage.
// master = issue logic / consumer side, slave = ex_stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic        is_valid;
  logic        is_ready;
  RS_IDX       is_rs_idx;
  TAG          is_dest;
  ALU_FUNC     is_alu_func;
  logic [31:0] is_opa;
  logic [31:0] is_opb;

  TAG          cdb;
  logic        cdb_en;
  logic [31:0] cdb_value;
  EX_RS_PACKET ex_rs_packet;

  modport master (
    output is_valid, is_rs_idx, is_dest, is_alu_func, is_opa, is_opb,
    input  is_ready, cdb, cdb_en, cdb_value, ex_rs_packet
  );

  modport slave (
    input  is_valid, is_rs_idx, is_dest, is_alu_func, is_opa, is_opb,
    output is_ready, cdb, cdb_en, cdb_value, ex_rs_packet
  );

endinterface

// File: rtl/ex_stage_mult_pipe.sv
// ex_stage_mult_pipe (the mult_pipe sub-module): fixed-latency multiplier.
// The 64-bit product is formed on entry; the remaining stages carry the
// selected 32-bit half so the result appears STAGES cycles after in_valid.
// It never stalls: the arbiter in ex_stage always gives its output the CDB.
module ex_stage_mult_pipe
  import ex_stage_pkg::*;
#(
  parameter int STAGES = MULT_STAGES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  ALU_FUNC     in_func,
  input  logic [31:0] in_opa,
  input  logic [31:0] in_opb,
  input  TAG          in_tag,
  input  RS_IDX       in_idx,
  output EX_RESULT    out,
  output logic        busy
);

  logic [STAGES-1:0] vld;
  EX_PAYLOAD         pay [STAGES];

  logic        a_sgn;
  logic        b_sgn;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;
  logic [31:0] first_value;

  // Sign-extend per function so one 64-bit modular multiply covers all four.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    a_sgn       = 1'b0;
    b_sgn       = 1'b0;
    a_sgn       = in_func inside {ALU_MULH, ALU_MULHSU};
    b_sgn       = (in_func == ALU_MULH);
    a64         = {{32{a_sgn & in_opa[31]}}, in_opa};
    b64         = {{32{b_sgn & in_opb[31]}}, in_opb};
    prod        = a64 * b64;
    first_value = (in_func == ALU_MUL) ? prod[31:0] : prod[63:32];
  end

  // Valid shift chain: cleared by reset and by a flush.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: flops use non-blocking <= so every stage samples its neighbour's
    // pre-edge value; blocking = here would collapse the chain.
    if (reset) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld <= {vld[STAGES-2:0], in_valid};
    end
  end

  // Payload shift chain travelling alongside the valids.
  always_ff @(posedge clock) begin
    // NOTE: payload storage is deliberately not reset; the valid bits alone
    // decide whether it means anything.
    pay[0] <= '{tag: in_tag, rs_idx: in_idx, value: first_value};
    for (int i = 1; i < STAGES; i++) begin
      pay[i] <= pay[i-1];
    end
  end

  assign out = '{valid:  vld[STAGES-1],
                 tag:    pay[STAGES-1].tag,
                 rs_idx: pay[STAGES-1].rs_idx,
                 value:  pay[STAGES-1].value};

  assign busy = |vld;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with an inline single-cycle ALU feeding a one-entry
// holding buffer (alu_q), a fixed-latency multiplier (ex_stage_mult_pipe) and
// a one-broadcast-per-cycle CDB arbiter where a completing multiply wins.
// Optional feature macro: MULT_PIPELINE_EN -- when defined the multiplier
// accepts a new op every cycle; otherwise it holds one op at a time.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MULT_STAGES = MULT_STAGES_DEF
) (
  input logic      clock,
  input logic      reset,
  input logic      interrupt,
  ex_stage_if.slave ex_if
);

  if (MULT_STAGES < 2 || MULT_STAGES > 8) begin : g_bad_stages
    $error("ex_stage: MULT_STAGES must lie in 2..8");
  end

  logic      is_mult;
  logic      accept;
  logic      alu_accept;
  logic      mult_accept;
  logic      alu_bcast;
  logic      ready_alu;
  logic      ready_mult;
  logic      mult_busy;

  logic      alu_vld;
  EX_PAYLOAD alu_pay;
  EX_RESULT  alu_q;
  EX_RESULT  mult_out;
  EX_RESULT  bcast;

  assign is_mult     = is_mult_func(ex_if.is_alu_func);
  assign accept      = ex_if.is_valid & ex_if.is_ready;
  assign alu_accept  = accept & ~is_mult;
  assign mult_accept = accept & is_mult;

  assign alu_q = '{valid:  alu_vld,
                   tag:    alu_pay.tag,
                   rs_idx: alu_pay.rs_idx,
                   value:  alu_pay.value};

  ex_stage_mult_pipe #(
    .STAGES (MULT_STAGES)
  ) u_mult_pipe (
    .clock    (clock),
    .reset    (reset),
    .flush    (interrupt),
    .in_valid (mult_accept),
    .in_func  (ex_if.is_alu_func),
    .in_opa   (ex_if.is_opa),
    .in_opb   (ex_if.is_opb),
    .in_tag   (ex_if.is_dest),
    .in_idx   (ex_if.is_rs_idx),
    .out      (mult_out),
    .busy     (mult_busy)
  );

  // CDB arbitration: multiply output first, then alu_q; nothing while flushing.
  always_comb begin
    bcast     = '0;
    alu_bcast = 1'b0;
    if (!interrupt) begin
      if (mult_out.valid) begin
        bcast = mult_out;
      end else if (alu_q.valid) begin
        bcast     = alu_q;
        alu_bcast = 1'b1;
      end
    end
  end

  // Issue readiness per class; independent of is_valid.
  always_comb begin
    ready_alu = ~alu_vld | alu_bcast;
`ifdef MULT_PIPELINE_EN
    ready_mult = 1'b1;
`else
    // A single op in flight; the slot frees in the cycle its result leaves.
    ready_mult = ~mult_busy | mult_out.valid;
`endif
    ex_if.is_ready = ~interrupt & (is_mult ? ready_mult : ready_alu);
  end

  // alu_q valid bit: load on ALU accept, drop when broadcast or flushed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_vld <= 1'b0;
    end else if (interrupt) begin
      alu_vld <= 1'b0;
    end else if (alu_accept) begin
      alu_vld <= 1'b1;
    end else if (alu_bcast) begin
      alu_vld <= 1'b0;
    end
  end

  // alu_q payload: captured only on accept, otherwise held for retry.
  always_ff @(posedge clock) begin
    if (alu_accept) begin
      alu_pay <= '{tag:    ex_if.is_dest,
                   rs_idx: ex_if.is_rs_idx,
                   value:  alu_compute(ex_if.is_alu_func, ex_if.is_opa, ex_if.is_opb)};
    end
  end

  assign ex_if.cdb_en       = bcast.valid;
  assign ex_if.cdb          = bcast.tag;
  assign ex_if.cdb_value    = bcast.value;
  assign ex_if.ex_rs_packet = '{remove_en: bcast.valid, remove_idx: bcast.rs_idx};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scenarios followed by random traffic, every cycle
// compared against a cycle-scheduled reference model of ex_stage.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int S = 4;
`ifdef MULT_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic interrupt;

  ex_stage_if ifc ();

  ex_stage #(.MULT_STAGES(S)) dut (
    .clock     (clock),
    .reset     (reset),
    .interrupt (interrupt),
    .ex_if     (ifc)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    TAG          tag;
    RS_IDX       idx;
    logic [31:0] val;
  } exp_t;

  exp_t mq[$];
  exp_t alu_e;
  bit   alu_have = 1'b0;
  bit   last_acc = 1'b0;

  logic        obs_en, obs_rem, obs_rdy;
  TAG          obs_tag;
  RS_IDX       obs_idx;
  logic [31:0] obs_val;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_is_mult(ALU_FUNC f);
    return (f == ALU_MUL) || (f == ALU_MULH) || (f == ALU_MULHSU) || (f == ALU_MULHU);
  endfunction

  // Reference results from plain 32/64-bit arithmetic.
  function automatic logic [31:0] ref_calc(ALU_FUNC f, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa = {{32{a[31]}}, a};
    logic [63:0] ua = {32'b0, a};
    logic [63:0] sb = {{32{b[31]}}, b};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p;
    int          sh = int'(b % 32);
    case (f)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SLL:    return a << sh;
      ALU_SRL:    return a >> sh;
      ALU_SRA:    begin p = sa >> sh; return p[31:0]; end
      ALU_SLT:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      ALU_MUL:    begin p = ua * ub; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      default:    begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  task automatic drive(input bit v, input ALU_FUNC f, input logic [31:0] a, input logic [31:0] b,
                       input TAG d, input RS_IDX i);
    ifc.is_valid    = v;
    ifc.is_alu_func = f;
    ifc.is_opa      = a;
    ifc.is_opb      = b;
    ifc.is_dest     = d;
    ifc.is_rs_idx   = i;
  endtask

  task automatic idle();
    drive(1'b0, ALU_ADD, 32'd0, 32'd0, '0, '0);
  endtask

  task automatic model_clear();
    mq.delete();
    alu_have = 1'b0;
  endtask

  // One clock cycle: compare outputs at the falling edge, advance the model.
  task automatic tick();
    bit   is_m, m_due, m_now, a_now, exp_rdy;
    exp_t e;
    @(negedge clock);
    is_m  = ref_is_mult(ifc.is_alu_func);
    m_due = (mq.size() > 0) && (mq[0].due == cyc);
    m_now = m_due && !interrupt;
    a_now = !m_due && alu_have && !interrupt;
    e     = m_now ? mq[0] : alu_e;

    obs_en  = ifc.cdb_en;
    obs_tag = ifc.cdb;
    obs_val = ifc.cdb_value;
    obs_rem = ifc.ex_rs_packet.remove_en;
    obs_idx = ifc.ex_rs_packet.remove_idx;
    obs_rdy = ifc.is_ready;

    if (m_now || a_now) begin
      check("cdb_en",     64'(obs_en),  64'(1));
      check("cdb",        64'(obs_tag), 64'(e.tag));
      check("cdb_value",  64'(obs_val), 64'(e.val));
      check("remove_en",  64'(obs_rem), 64'(1));
      check("remove_idx", 64'(obs_idx), 64'(e.idx));
    end else begin
      check("cdb_en_idle",     64'(obs_en),  64'(0));
      check("cdb_idle",        64'(obs_tag), 64'(0));
      check("cdb_value_idle",  64'(obs_val), 64'(0));
      check("remove_en_idle",  64'(obs_rem), 64'(0));
      check("remove_idx_idle", 64'(obs_idx), 64'(0));
    end

    if (interrupt)  exp_rdy = 1'b0;
    else if (is_m)  exp_rdy = PIPE || (mq.size() == 0) || m_due;
    else            exp_rdy = !alu_have || a_now;
    check("is_ready", 64'(obs_rdy), 64'(exp_rdy));

    last_acc = ifc.is_valid && exp_rdy;
    if (interrupt) begin
      model_clear();
    end else begin
      if (m_now) void'(mq.pop_front());
      if (a_now) alu_have = 1'b0;
      if (last_acc) begin
        e = '{due: cyc + S, tag: ifc.is_dest, idx: ifc.is_rs_idx,
              val: ref_calc(ifc.is_alu_func, ifc.is_opa, ifc.is_opb)};
        if (is_m) begin
          mq.push_back(e);
        end else begin
          alu_e    = e;
          alu_have = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic mul_once(input string tag, input ALU_FUNC f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_val);
    drive(1'b1, f, a, b, 6'd40, 4'd9);
    tick();
    idle();
    repeat (S) tick();
    check({tag, "_en"},  64'(obs_en),  64'(1));
    check({tag, "_val"}, 64'(obs_val), 64'(exp_val));
  endtask

  initial begin
    int waited;
    reset     = 1'b0;
    interrupt = 1'b0;
    idle();

    // Reset state.
    #1 reset = 1'b1;
    #2;
    check("rst_cdb_en",    64'(ifc.cdb_en),                  64'(0));
    check("rst_remove_en", 64'(ifc.ex_rs_packet.remove_en),  64'(0));
    check("rst_cdb_value", 64'(ifc.cdb_value),               64'(0));
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    check("ready_after_reset", 64'(obs_rdy), 64'(1));

    // ADD 5+7 -> broadcast next cycle.
    drive(1'b1, ALU_ADD, 32'd5, 32'd7, 6'd12, 4'd3);
    tick();
    idle();
    tick();
    check("add_cdb_en",     64'(obs_en),  64'(1));
    check("add_cdb",        64'(obs_tag), 64'(12));
    check("add_cdb_value",  64'(obs_val), 64'(12));
    check("add_remove_en",  64'(obs_rem), 64'(1));
    check("add_remove_idx", 64'(obs_idx), 64'(3));

    // Multiply corner values, broadcast at T+S.
    mul_once("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'd2,        32'h1);
    mul_once("mulh",  ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    mul_once("mul",   ALU_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);

    // MUL at T, ADD at T+3: MUL wins at T+4, ADD waits until T+5.
    drive(1'b1, ALU_MUL, 32'd3, 32'd4, 6'd50, 4'd1);
    tick();
    idle();
    tick();
    tick();
    drive(1'b1, ALU_ADD, 32'd1, 32'd1, 6'd51, 4'd2);
    tick();
    drive(1'b0, ALU_ADD, 32'd0, 32'd0, '0, '0);
    tick();
    check("collide_mul_tag",  64'(obs_tag), 64'(50));
    check("collide_alu_rdy",  64'(obs_rdy), 64'(0));
    tick();
    check("collide_add_tag",  64'(obs_tag), 64'(51));
    check("collide_add_val",  64'(obs_val), 64'(2));

    // Four back-to-back ADDs.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ALU_ADD, 32'(i), 32'(i), TAG'(20 + i), RS_IDX'(i));
      tick();
      check("b2b_ready", 64'(obs_rdy), 64'(1));
      if (i > 0) check("b2b_idx", 64'(obs_idx), 64'(i - 1));
    end
    idle();
    tick();
    check("b2b_last_idx", 64'(obs_idx), 64'(3));

    // MUL then MUL: acceptance of the second depends on pipelining.
    drive(1'b1, ALU_MUL, 32'd6, 32'd7, 6'd30, 4'd4);
    tick();
    drive(1'b1, ALU_MUL, 32'd8, 32'd9, 6'd31, 4'd5);
    waited = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      waited++;
      if (last_acc) break;
    end
    check("mul_mul_wait", 64'(waited), PIPE ? 64'(1) : 64'(S));
    idle();
    repeat (S + 1) tick();

    // Interrupt with a MUL and an ADD in flight.
    drive(1'b1, ALU_MUL, 32'd11, 32'd13, 6'd33, 4'd6);
    tick();
    drive(1'b1, ALU_ADD, 32'd2, 32'd3, 6'd34, 4'd7);
    tick();
    idle();
    interrupt = 1'b1;
    tick();
    check("intr_ready", 64'(obs_rdy), 64'(0));
    interrupt = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      tick();
      check("intr_no_cdb",    64'(obs_en),  64'(0));
      check("intr_no_remove", 64'(obs_rem), 64'(0));
    end

    // Asynchronous reset pulsed in the middle of a cycle.
    drive(1'b1, ALU_MUL, 32'd5, 32'd5, 6'd35, 4'd8);
    tick();
    drive(1'b1, ALU_ADD, 32'd9, 32'd9, 6'd36, 4'd10);
    tick();
    idle();
    #1 reset = 1'b1;
    #1;
    check("arst_cdb_en",     64'(ifc.cdb_en),                  64'(0));
    check("arst_cdb",        64'(ifc.cdb),                     64'(0));
    check("arst_cdb_value",  64'(ifc.cdb_value),               64'(0));
    check("arst_remove_en",  64'(ifc.ex_rs_packet.remove_en),  64'(0));
    check("arst_remove_idx", 64'(ifc.ex_rs_packet.remove_idx), 64'(0));
    #1 reset = 1'b0;
    model_clear();
    repeat (S + 2) tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'(b % 32);
        default: ;
      endcase
      interrupt = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 3) != 0, ALU_FUNC'(4'($urandom_range(0, 13))), a, b,
            TAG'($urandom()), RS_IDX'($urandom()));
      tick();
    end
    interrupt = 1'b0;
    idle();
    repeat (S + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: MULT_STAGES, default 4, multiplier latency in cycles (legal range 2..8).
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: interrupt  input  1  synchronous flush of all in-flight work.
REQ-005 Port: is_valid  input  1  the issue side presents an instruction this cycle.
REQ-006 Port: is_ready  output  1  ex_stage accepts the presented instruction this cycle.
REQ-007 Port: is_rs_idx  input  $clog2(`RS_SZ)  RS slot of the instruction.
REQ-008 Port: is_dest  input  TAG  destination physical-register tag.
REQ-009 Port: is_alu_func  input  ALU_FUNC  operation selector.
REQ-010 Port: is_opa, is_opb  input  32 each  source operand values.
REQ-011 Port: cdb  output  TAG  broadcast destination tag.
REQ-012 Port: cdb_en  output  1  broadcast valid.
REQ-013 Port: cdb_value  output  32  broadcast result.
REQ-014 Port: ex_rs_packet  output  EX_RS_PACKET  remove_en and remove_idx returned to the RS.

Function
REQ-015 An instruction is accepted only on a cycle where is_valid and is_ready are both 1.
REQ-016 Class is MULT when is_alu_func is ALU_MUL, ALU_MULH, ALU_MULHSU or ALU_MULHU; every other function is class ALU.
REQ-017 ALU class: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, all 32-bit wraparound; shift amount is opb[4:0]; SLT is signed, SLTU is unsigned.
REQ-018 MULT class: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32] of the 64-bit product, with operands signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-019 ALU result is registered into a 1-entry holding buffer alu_q (valid, tag, idx, value) at the end of the accept cycle.
REQ-020 A MULT result leaves the multiplier exactly MULT_STAGES cycles after acceptance; the multiplier never stalls.
REQ-021 CDB arbitration, one broadcast per cycle: a completing MULT result wins; otherwise alu_q broadcasts if valid.
REQ-022 A broadcast drives cdb, cdb_value and cdb_en=1; in the same cycle it drives ex_rs_packet.remove_en=1 with remove_idx equal to that instruction's rs_idx.
REQ-023 An alu_q entry that loses arbitration is held unchanged and retries next cycle.
REQ-024 ALU best-case latency: accept in cycle T, broadcast in T+1.
REQ-025 MULT best-case latency: accept in cycle T, broadcast in T+MULT_STAGES.
REQ-026 is_ready for an ALU op is 1 iff alu_q is empty, or alu_q broadcasts this cycle; this permits back-to-back ALU ops at one per cycle.
REQ-027 is_ready for a MULT op follows the Configuration section.
REQ-028 is_ready is combinational from is_alu_func and internal state only; it never depends on is_valid.
REQ-029 interrupt=1 clears alu_q and all multiplier stage valids at the next clock edge; is_ready is 0 while interrupt is high; no broadcast follows a flushed instruction.
REQ-030 When cdb_en=0, cdb and cdb_value are 0.

Reset
REQ-031 While reset=1, immediately clear: alu_q.valid, all multiplier valids, cdb_en, remove_en, cdb, cdb_value, remove_idx.
REQ-032 Reset asserted mid-operation discards all in-flight instructions; none is broadcast after reset deasserts.
REQ-033 is_ready is 1 on the first cycle after reset deasserts.

Configuration
REQ-034 Macro MULT_PIPELINE_EN, when defined: the multiplier is fully pipelined, MULT is accepted every cycle, and is_ready for MULT is 1.
REQ-035 Macro MULT_PIPELINE_EN, when undefined: the multiplier holds one op at a time, is_ready for MULT is 0 from acceptance until the cycle of its broadcast (inclusive of the broadcast cycle returning 1), and latency stays MULT_STAGES.

Structure
REQ-036 In sys_defs.svh: EX_RS_PACKET, TAG, ALU_FUNC, the MULT_STAGES default, and a new EX_RESULT struct (valid, tag, rs_idx, value).
REQ-037 One sub-module, mult_pipe, holds the MULT_STAGES-deep multiplier and its per-stage EX_RESULT valid/tag/idx shift chain; the ALU and the arbiter are inline.

Verification
REQ-038 Scenario: ADD opa=5, opb=7, dest=12, idx=3 accepted in cycle T -> cycle T+1: cdb_en=1, cdb=12, cdb_value=12, remove_en=1, remove_idx=3.
REQ-039 Scenario: MULHU opa=0xFFFFFFFF, opb=2 -> broadcast at T+4 with cdb_value=0x1; MULH opa=-1, opb=-1 -> cdb_value=0x0; MUL opa=-1, opb=-1 -> 0x1.
REQ-040 Scenario: MUL at T, then ADD at T+3 -> at T+4 the MUL broadcasts, the ADD waits in alu_q and broadcasts at T+5, and is_ready for ALU is 0 at T+4.
REQ-041 Scenario: four back-to-back ADDs -> four consecutive broadcasts in order with matching remove_idx, and is_ready stays 1.
REQ-042 Scenario: MUL then MUL on the next cycle, with MULT_PIPELINE_EN undefined -> second is_ready=0 until the first broadcasts; with the macro defined, both are accepted and broadcast on consecutive cycles.
REQ-043 Scenario: interrupt at T+2 with a MUL and an ALU in flight -> no cdb_en and no remove_en through T+8.
REQ-044 Scenario: async reset pulsed mid-cycle -> all outputs are 0 immediately.
